// File: rtl/peripheral_bus_arbiter.sv
// Round-robin arbiter sharing one peripheral register bus between masters.
// Ports: m_* request/response per master, per_* peripheral bus, busy status.
module peripheral_bus_arbiter #(
    parameter int NUM_MASTERS  = 2,
    parameter int ADDR_WIDTH   = 2,
    parameter int DATA_WIDTH   = 32,
    parameter int READ_TIMEOUT = 15
) (
    input  logic                              clk,
    input  logic                              reset,
    input  logic [NUM_MASTERS-1:0]            m_read,
    input  logic [NUM_MASTERS-1:0]            m_write,
    input  logic [NUM_MASTERS*ADDR_WIDTH-1:0] m_address,
    input  logic [NUM_MASTERS*DATA_WIDTH-1:0] m_data_in,
    output logic [NUM_MASTERS-1:0]            m_ack,
    output logic [NUM_MASTERS-1:0]            m_read_valid,
    output logic [NUM_MASTERS-1:0]            m_error,
    output logic [DATA_WIDTH-1:0]             m_read_data,
    output logic                              per_read,
    output logic                              per_write,
    output logic [ADDR_WIDTH-1:0]             per_address,
    output logic [DATA_WIDTH-1:0]             per_data_in,
    input  logic                              per_read_valid,
    input  logic [DATA_WIDTH-1:0]             per_data_out,
    output logic                              busy
);

    localparam int PW = (NUM_MASTERS > 1) ? $clog2(NUM_MASTERS) : 1;
    localparam int CW = $clog2(READ_TIMEOUT + 1);

    localparam logic [1:0] IDLE  = 2'd0;
    localparam logic [1:0] ISSUE = 2'd1;
    localparam logic [1:0] WAIT  = 2'd2;
    localparam logic [1:0] RESP  = 2'd3;

    logic [1:0]             state;
    logic [PW-1:0]          ptr;
    logic [PW-1:0]          grant;
    logic                   op_read;
    logic [CW-1:0]          cnt;
    logic [NUM_MASTERS-1:0] req;
    logic                   found;
    logic [PW-1:0]          sel;
    logic [PW-1:0]          sel_next;

    logic [ADDR_WIDTH-1:0] addr_a [NUM_MASTERS];
    logic [DATA_WIDTH-1:0] data_a [NUM_MASTERS];

    for (genvar g = 0; g < NUM_MASTERS; g++) begin : g_unpack
        assign addr_a[g] = m_address[g*ADDR_WIDTH +: ADDR_WIDTH];
        assign data_a[g] = m_data_in[g*DATA_WIDTH +: DATA_WIDTH];
    end

    // First requester at or after the pointer, wrapping around.
    always_comb begin
        int j;
        int k;
        j        = 0;
        k        = 0;
        req      = m_read | m_write;
        found    = 1'b0;
        sel      = '0;
        for (int i = 0; i < NUM_MASTERS; i++) begin
            j = int'(ptr) + i;
            if (j >= NUM_MASTERS) j = j - NUM_MASTERS;
            if (!found && req[PW'(j)]) begin
                found = 1'b1;
                sel   = PW'(j);
            end
        end
        k = int'(sel) + 1;
        if (k >= NUM_MASTERS) k = 0;
        sel_next = PW'(k);
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state        <= IDLE;
            ptr          <= '0;
            grant        <= '0;
            op_read      <= 1'b0;
            cnt          <= '0;
            m_ack        <= '0;
            m_read_valid <= '0;
            m_error      <= '0;
            m_read_data  <= '0;
            per_read     <= 1'b0;
            per_write    <= 1'b0;
            per_address  <= '0;
            per_data_in  <= '0;
            busy         <= 1'b0;
        end else begin
            m_ack        <= '0;
            m_read_valid <= '0;
            m_error      <= '0;
            per_read     <= 1'b0;
            per_write    <= 1'b0;
            unique case (state)
                IDLE: begin
                    if (found) begin
                        // A simultaneous read+write is executed as a write.
                        grant       <= sel;
                        ptr         <= sel_next;
                        op_read     <= !m_write[sel];
                        per_read    <= !m_write[sel];
                        per_write   <= m_write[sel];
                        per_address <= addr_a[sel];
                        per_data_in <= data_a[sel];
                        busy        <= 1'b1;
                        state       <= ISSUE;
                    end
                end
                ISSUE: begin
                    if (!op_read) begin
                        m_ack[grant] <= 1'b1;
                        state        <= RESP;
                    end else if (per_read_valid) begin
                        m_read_data         <= per_data_out;
                        m_ack[grant]        <= 1'b1;
                        m_read_valid[grant] <= 1'b1;
                        state               <= RESP;
                    end else begin
                        cnt   <= '0;
                        state <= WAIT;
                    end
                end
                WAIT: begin
                    if (per_read_valid) begin
                        m_read_data         <= per_data_out;
                        m_ack[grant]        <= 1'b1;
                        m_read_valid[grant] <= 1'b1;
                        state               <= RESP;
                    end else if (cnt == CW'(READ_TIMEOUT - 1)) begin
                        cnt            <= cnt + 1'b1;
                        m_read_data    <= '0;
                        m_ack[grant]   <= 1'b1;
                        m_error[grant] <= 1'b1;
                        state          <= RESP;
                    end else begin
                        cnt <= cnt + 1'b1;
                    end
                end
                RESP: begin
                    busy  <= 1'b0;
                    state <= IDLE;
                end
                default: begin
                    busy  <= 1'b0;
                    state <= IDLE;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_peripheral_bus_arbiter.sv
// Self-checking bench for peripheral_bus_arbiter.
// Directed scenarios plus randomized traffic against a round-robin model.
module tb_peripheral_bus_arbiter;

    localparam int N  = 2;
    localparam int AW = 2;
    localparam int DW = 32;
    localparam int T  = 15;

    logic            clk;
    logic            reset;
    logic [N-1:0]    m_read;
    logic [N-1:0]    m_write;
    logic [N*AW-1:0] m_address;
    logic [N*DW-1:0] m_data_in;
    logic [N-1:0]    m_ack;
    logic [N-1:0]    m_read_valid;
    logic [N-1:0]    m_error;
    logic [DW-1:0]   m_read_data;
    logic            per_read;
    logic            per_write;
    logic [AW-1:0]   per_address;
    logic [DW-1:0]   per_data_in;
    logic            per_read_valid;
    logic [DW-1:0]   per_data_out;
    logic            busy;

    int n_tests;
    int n_fail;

    peripheral_bus_arbiter #(
        .NUM_MASTERS(N), .ADDR_WIDTH(AW),
        .DATA_WIDTH(DW), .READ_TIMEOUT(T)
    ) dut (
        .clk(clk), .reset(reset),
        .m_read(m_read), .m_write(m_write),
        .m_address(m_address), .m_data_in(m_data_in),
        .m_ack(m_ack), .m_read_valid(m_read_valid),
        .m_error(m_error), .m_read_data(m_read_data),
        .per_read(per_read), .per_write(per_write),
        .per_address(per_address), .per_data_in(per_data_in),
        .per_read_valid(per_read_valid),
        .per_data_out(per_data_out), .busy(busy)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    initial begin
        #1000000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1);
    end

    task automatic tick;
        @(posedge clk);
        #1;
    endtask

    task automatic idle_inputs;
        m_read = '0; m_write = '0;
        m_address = '0; m_data_in = '0;
        per_read_valid = 1'b0; per_data_out = '0;
    endtask

    // Holds write requests for the masters in mask, dropping each on ack.
    task automatic run_writes(input logic [N-1:0] mask,
                              output int first, output int second,
                              output logic [DW-1:0] d_first,
                              output int nack);
        logic [N-1:0] held;
        int nstb;
        first = -1; second = -1; d_first = '0; nack = 0;
        held = mask; nstb = 0;
        m_write = mask;
        for (int c = 0; c < 20 && held != 0; c++) begin
            tick;
            if (per_write && nstb == 0) begin
                d_first = per_data_in;
                nstb++;
            end
            for (int i = 0; i < N; i++) begin
                if (m_ack[i]) begin
                    if (nack == 0) first = i;
                    else second = i;
                    nack++;
                    held[i] = 1'b0;
                    m_write[i] = 1'b0;
                end
            end
        end
        tick;
    endtask

    task automatic test_reset;
        reset = 1'b1;
        idle_inputs;
        tick; tick;
        n_tests++;
        if (busy !== 1'b0) begin
            n_fail++; $display("FAIL reset_busy: got %b want 0", busy);
        end
        n_tests++;
        if ({m_ack, m_read_valid, m_error} !== '0) begin
            n_fail++;
            $display("FAIL reset_m: got %b%b%b want 0",
                     m_ack, m_read_valid, m_error);
        end
        n_tests++;
        if (m_read_data !== '0) begin
            n_fail++; $display("FAIL reset_rdata: got %h want 0", m_read_data);
        end
        n_tests++;
        if ({per_read, per_write, per_address, per_data_in} !== '0) begin
            n_fail++;
            $display("FAIL reset_per: got r%b w%b a%h d%h want 0",
                     per_read, per_write, per_address, per_data_in);
        end
        reset = 1'b0;
        tick;
    endtask

    task automatic test_write;
        m_write = 2'b01; m_address = '0;
        m_data_in = {32'd0, 32'd67};
        tick;
        n_tests++;
        if (per_write !== 1'b1 || per_read !== 1'b0 || per_address !== 2'd0
            || per_data_in !== 32'd67 || busy !== 1'b1 || m_ack !== 2'b00) begin
            n_fail++;
            $display("FAIL write_issue: got w%b r%b a%h d%0d busy%b ack%b want w1 r0 a0 d67 busy1 ack00",
                     per_write, per_read, per_address, per_data_in, busy, m_ack);
        end
        tick;
        n_tests++;
        if (per_write !== 1'b0 || m_ack !== 2'b01 || busy !== 1'b1) begin
            n_fail++;
            $display("FAIL write_ack: got w%b ack%b busy%b want w0 ack01 busy1",
                     per_write, m_ack, busy);
        end
        m_write = '0;
        tick;
        n_tests++;
        if (m_ack !== 2'b00 || busy !== 1'b0 || per_write !== 1'b0) begin
            n_fail++;
            $display("FAIL write_done: got ack%b busy%b w%b want 00 0 0",
                     m_ack, busy, per_write);
        end
    endtask

    task automatic test_read;
        int bad;
        bad = 0;
        m_read = 2'b10; m_address = 4'b0100;
        tick;
        n_tests++;
        if (per_read !== 1'b1 || per_write !== 1'b0 || per_address !== 2'd1) begin
            n_fail++;
            $display("FAIL read_issue: got r%b w%b a%h want r1 w0 a1",
                     per_read, per_write, per_address);
        end
        for (int k = 1; k <= 3; k++) begin
            tick;
            if (m_ack !== 2'b00 || per_read !== 1'b0) bad++;
        end
        per_read_valid = 1'b1; per_data_out = 32'd3;
        tick;
        per_read_valid = 1'b0; per_data_out = '0;
        n_tests++;
        if (bad != 0 || m_ack !== 2'b10 || m_read_valid !== 2'b10
            || m_error !== 2'b00 || m_read_data !== 32'd3) begin
            n_fail++;
            $display("FAIL read_resp: early%0d ack%b rv%b err%b data%0d want 0 10 10 00 3",
                     bad, m_ack, m_read_valid, m_error, m_read_data);
        end
        m_read = '0;
        tick;
        n_tests++;
        if (m_ack !== 2'b00 || busy !== 1'b0) begin
            n_fail++;
            $display("FAIL read_done: got ack%b busy%b want 00 0", m_ack, busy);
        end
    endtask

    task automatic test_round_robin;
        int f, s, na;
        logic [DW-1:0] d;
        reset = 1'b1; idle_inputs; tick; reset = 1'b0;
        m_data_in = {32'd9, 32'd5};
        run_writes(2'b11, f, s, d, na);
        n_tests++;
        if (na != 2 || f != 0 || s != 1 || d !== 32'd5) begin
            n_fail++;
            $display("FAIL rr_first_pair: acks%0d order %0d,%0d data%0d want 2 0,1 5",
                     na, f, s, d);
        end
        run_writes(2'b01, f, s, d, na);
        n_tests++;
        if (na != 1 || f != 0) begin
            n_fail++;
            $display("FAIL rr_single: acks%0d first%0d want 1 0", na, f);
        end
        run_writes(2'b11, f, s, d, na);
        n_tests++;
        if (na != 2 || f != 1 || s != 0 || d !== 32'd9) begin
            n_fail++;
            $display("FAIL rr_rotated: acks%0d order %0d,%0d data%0d want 2 1,0 9",
                     na, f, s, d);
        end
    endtask

    task automatic test_timeout;
        int bad;
        bad = 0;
        m_read = 2'b01; m_address = '0;
        tick;
        for (int k = 1; k <= T; k++) begin
            tick;
            if (m_ack !== 2'b00) bad++;
        end
        tick;
        n_tests++;
        if (bad != 0 || m_ack !== 2'b01 || m_error !== 2'b01
            || m_read_valid !== 2'b00 || m_read_data !== '0) begin
            n_fail++;
            $display("FAIL timeout_resp: early%0d ack%b err%b rv%b data%h want 0 01 01 00 0",
                     bad, m_ack, m_error, m_read_valid, m_read_data);
        end
        m_read = '0;
        per_read_valid = 1'b1; per_data_out = 32'hdead_beef;
        tick; tick;
        n_tests++;
        if (m_ack !== 2'b00 || busy !== 1'b0 || m_read_valid !== 2'b00) begin
            n_fail++;
            $display("FAIL timeout_late: got ack%b busy%b rv%b want 00 0 00",
                     m_ack, busy, m_read_valid);
        end
        per_read_valid = 1'b0; per_data_out = '0;
    endtask

    task automatic test_reset_mid;
        int bad, f, s, na;
        logic [DW-1:0] d;
        bad = 0;
        m_read = 2'b01; m_address = 4'b0011;
        tick; tick; tick;
        reset = 1'b1; m_read = '0;
        tick;
        n_tests++;
        if (busy !== 1'b0 || {m_ack, m_read_valid, m_error} !== '0
            || m_read_data !== '0 || per_read !== 1'b0 || per_write !== 1'b0
            || per_address !== '0 || per_data_in !== '0) begin
            n_fail++;
            $display("FAIL midreset_clear: busy%b ack%b a%h want all 0",
                     busy, m_ack, per_address);
        end
        reset = 1'b0;
        per_read_valid = 1'b1; per_data_out = 32'h1234;
        for (int k = 0; k < 3; k++) begin
            tick;
            if (m_ack !== 2'b00 || busy !== 1'b0) bad++;
            per_read_valid = 1'b0;
        end
        n_tests++;
        if (bad != 0) begin
            n_fail++;
            $display("FAIL midreset_noack: bad cycles %0d want 0", bad);
        end
        m_data_in = {32'd2, 32'd1}; m_address = '0;
        run_writes(2'b11, f, s, d, na);
        n_tests++;
        if (na != 2 || f != 0) begin
            n_fail++;
            $display("FAIL midreset_grant: acks%0d first%0d want 2 0", na, f);
        end
    endtask

    task automatic test_rw_both;
        int acks;
        acks = 0;
        m_read = 2'b01; m_write = 2'b01;
        m_address = 4'b0010; m_data_in = {32'd0, 32'd7};
        tick;
        n_tests++;
        if (per_write !== 1'b1 || per_read !== 1'b0 || per_address !== 2'd2
            || per_data_in !== 32'd7) begin
            n_fail++;
            $display("FAIL rw_issue: got w%b r%b a%h d%0d want w1 r0 a2 d7",
                     per_write, per_read, per_address, per_data_in);
        end
        tick;
        if (m_ack[0]) acks++;
        n_tests++;
        if (m_ack !== 2'b01 || m_read_valid !== 2'b00) begin
            n_fail++;
            $display("FAIL rw_ack: got ack%b rv%b want 01 00", m_ack, m_read_valid);
        end
        m_read = '0; m_write = '0;
        for (int k = 0; k < 4; k++) begin
            tick;
            if (m_ack !== 2'b00) acks++;
        end
        n_tests++;
        if (acks != 1) begin
            n_fail++; $display("FAIL rw_single_ack: got %0d acks want 1", acks);
        end
    endtask

    task automatic test_random;
        int ptr, exp, lat, ack_k, w, bad;
        int op [N];
        logic [N-1:0] rem, oh;
        logic [AW-1:0] ad [N];
        logic [DW-1:0] dt [N];
        logic [DW-1:0] rd, exp_data;
        logic is_rd, exp_err;
        reset = 1'b1; idle_inputs; tick; reset = 1'b0;
        ptr = 0;
        for (int b = 0; b < 30; b++) begin
            rem = N'($urandom_range(1, (1 << N) - 1));
            for (int i = 0; i < N; i++) begin
                ad[i] = AW'($urandom);
                dt[i] = $urandom;
                op[i] = $urandom_range(0, 2);
                m_address[i*AW +: AW] = ad[i];
                m_data_in[i*DW +: DW] = dt[i];
                m_read[i]  = rem[i] && op[i] != 1;
                m_write[i] = rem[i] && op[i] != 0;
            end
            while (rem != 0) begin
                exp = -1;
                for (int k = 0; k < N; k++)
                    if (exp < 0 && rem[(ptr + k) % N]) exp = (ptr + k) % N;
                ptr = (exp + 1) % N;
                is_rd = (op[exp] == 0);
                oh = N'(1) << exp;
                w = 0;
                while (!(per_read || per_write) && w < 8) begin
                    tick; w++;
                end
                n_tests++;
                if (per_read !== is_rd || per_write !== !is_rd
                    || per_address !== ad[exp]
                    || (!is_rd && per_data_in !== dt[exp])) begin
                    n_fail++;
                    $display("FAIL rand_issue: m%0d r%b w%b a%h d%h want r%b a%h d%h",
                             exp, per_read, per_write, per_address,
                             per_data_in, is_rd, ad[exp], dt[exp]);
                end
                lat = is_rd ? $urandom_range(0, T + 1) : 99;
                ack_k = !is_rd ? 1 : (lat <= T ? lat + 1 : T + 1);
                rd = $urandom;
                exp_err = is_rd && lat > T;
                exp_data = exp_err ? '0 : rd;
                bad = 0;
                for (int k = 0; k < ack_k; k++) begin
                    per_read_valid = (k == lat);
                    per_data_out = rd;
                    if (m_ack !== '0) bad++;
                    tick;
                end
                per_read_valid = (lat == ack_k);
                n_tests++;
                if (bad != 0 || m_ack !== oh
                    || m_read_valid !== ((is_rd && !exp_err) ? oh : '0)
                    || m_error !== (exp_err ? oh : '0)
                    || (is_rd && m_read_data !== exp_data)) begin
                    n_fail++;
                    $display("FAIL rand_resp: m%0d lat%0d early%0d ack%b rv%b err%b data%h want ack%b err%b data%h",
                             exp, lat, bad, m_ack, m_read_valid, m_error,
                             m_read_data, oh, exp_err, exp_data);
                end
                m_read[exp] = 1'b0;
                m_write[exp] = 1'b0;
                rem[exp] = 1'b0;
                tick;
                per_read_valid = 1'b0;
            end
        end
    endtask

    initial begin
        n_tests = 0;
        n_fail = 0;
        reset = 1'b1;
        idle_inputs;
        test_reset;
        test_write;
        test_read;
        test_round_robin;
        test_timeout;
        test_reset_mid;
        test_rw_both;
        test_random;
        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule

// File: doc/peripheral_bus_arbiter.md
Name: peripheral_bus_arbiter

Overview:
- Shares one peripheral register bus (read/write/address/data_in in; read_valid/data_out back) between NUM_MASTERS requesters.
- Round-robin arbitration, one transaction in flight at a time.
- Issues a single-cycle read or write strobe to the peripheral, waits for read_valid on reads, then returns an ack (plus data or error) to the granted master.
- Sits between the masters (CPU, DMA) and peripheral_top.

Parameters:
- NUM_MASTERS, 2, number of requesters (2..8).
- ADDR_WIDTH, 2, peripheral address width.
- DATA_WIDTH, 32, data width.
- READ_TIMEOUT, 15, max cycles waited for per_read_valid before error response (1..255).

Ports:
- clk  input  1  clock
- reset  input  1  synchronous active-high reset
- m_read  input  NUM_MASTERS  per-master read request, held until m_ack
- m_write  input  NUM_MASTERS  per-master write request, held until m_ack
- m_address  input  NUM_MASTERS*ADDR_WIDTH  packed addresses, master i at [i*ADDR_WIDTH +: ADDR_WIDTH]
- m_data_in  input  NUM_MASTERS*DATA_WIDTH  packed write data, same packing
- m_ack  output  NUM_MASTERS  one-cycle completion pulse to granted master
- m_read_valid  output  NUM_MASTERS  one-cycle pulse with m_ack on read completion
- m_error  output  NUM_MASTERS  one-cycle pulse with m_ack on read timeout
- m_read_data  output  DATA_WIDTH  shared read data, valid only with m_read_valid
- per_read  output  1  read strobe to peripheral
- per_write  output  1  write strobe to peripheral
- per_address  output  ADDR_WIDTH  peripheral address
- per_data_in  output  DATA_WIDTH  peripheral write data
- per_read_valid  input  1  peripheral read data valid
- per_data_out  input  DATA_WIDTH  peripheral read data
- busy  output  1  high whenever state != IDLE

Behaviour:
- Interface: one clock, clk. Reset is synchronous and active-high (reset).
- All outputs are registered.
- On reset:
  - All outputs are 0.
  - State = IDLE, round-robin pointer = 0, timeout counter = 0.
- States:
  - IDLE: if any master has m_read|m_write, grant the first requesting master at or after the pointer, modulo NUM_MASTERS. Latch its address, data and op into per_*, assert per_read or per_write for the next cycle, go to ISSUE. Set pointer = (grant+1) mod NUM_MASTERS.
  - ISSUE: strobe high for exactly this one cycle; per_address/per_data_in are held stable through RESP. Write: go to RESP. Read: go to WAIT with counter cleared. per_read_valid is also sampled in ISSUE; if high, go straight to RESP with data.
  - WAIT: on per_read_valid, capture per_data_out into m_read_data and go to RESP. Otherwise increment the counter; when counter reaches READ_TIMEOUT, go to RESP with m_read_data = 0 and the error flag set.
  - RESP: m_ack[grant]=1 for one cycle. On reads, m_read_valid[grant]=1 on success or m_error[grant]=1 on timeout. Then IDLE.
- Latency:
  - Write: request seen in cycle N gives strobe in N+1 and ack in N+2.
  - Read: ack arrives 1 cycle after per_read_valid is sampled.
- The requester must drop its request in the cycle after m_ack. IDLE re-arbitrates in that cycle, so a request still held is treated as a new transaction.
- m_read and m_write both high from one master: executed as a write only; the read is dropped.
- Fairness: a continuously requesting master is granted at most once per NUM_MASTERS grants while others are also requesting.
- Requests arriving outside IDLE wait; nothing is queued beyond the held request lines.
- per_read_valid outside ISSUE/WAIT is ignored, including a late response after a timeout.
- Reset mid-transaction:
  - Outputs clear on the next edge and no ack is issued.
  - per_read_valid arriving after reset is ignored.
- Counter width: $clog2(READ_TIMEOUT+1); it never wraps.

Test Plan:
- Master 0 writes addr 0 data 67 (no contention) -> per_write high for exactly 1 cycle with per_address=0, per_data_in=67; m_ack[0] exactly 2 cycles after request; busy high 2 cycles.
- Master 1 reads addr 1 with peripheral returning 32'b11 three cycles after per_read -> m_read_valid[1]=m_ack[1]=1 with m_read_data=3; m_ack[0] stays 0.
- Both masters request writes (m0 data 5, m1 data 9) at once after reset, held until ack -> m0 serviced first, then m1. Next simultaneous pair -> m1 first (pointer rotated).
- Read with per_read_valid never asserted -> m_error and m_ack pulse exactly READ_TIMEOUT+1 cycles after ISSUE, m_read_data=0. A late per_read_valid is ignored and returns busy=0 to IDLE.
- Reset asserted during WAIT -> next cycle busy=0 and all m_*/per_* outputs 0. A following per_read_valid produces no ack. A new request afterwards is granted to master 0.
- Master 0 drives m_read and m_write together (addr 2, data 7) -> only per_write issued, m_read_valid[0] stays 0, a single m_ack[0].
